// File: rtl/rev_gate_pipe_if.sv
// Handshake/data bundle for rev_gate_pipe: upstream operand channel and downstream result channel.
// in_inv only exists when REV_GATE_INVERSE_EN is defined.
interface rev_gate_pipe_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
`ifdef REV_GATE_INVERSE_EN
    logic             in_inv;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_p;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_r;
    logic [1:0]       out_mode;
    logic [CNT_W-1:0] op_count;

`ifdef REV_GATE_INVERSE_EN
    modport master (output in_valid, in_mode, in_a, in_b, in_c, in_inv, out_ready,
                    input  in_ready, out_valid, out_p, out_q, out_r, out_mode, op_count);
    modport slave  (input  in_valid, in_mode, in_a, in_b, in_c, in_inv, out_ready,
                    output in_ready, out_valid, out_p, out_q, out_r, out_mode, op_count);
`else
    modport master (output in_valid, in_mode, in_a, in_b, in_c, out_ready,
                    input  in_ready, out_valid, out_p, out_q, out_r, out_mode, op_count);
    modport slave  (input  in_valid, in_mode, in_a, in_b, in_c, out_ready,
                    output in_ready, out_valid, out_p, out_q, out_r, out_mode, op_count);
`endif
endinterface

// File: rtl/rev_gate_pipe.sv
// Two-stage valid/ready pipeline applying a reversible gate (Feynman/Toffoli/Fredkin/Peres) per bit lane.
// Define REV_GATE_INVERSE_EN to add the in_inv input and the inverse Peres path.
module rev_gate_lane (
    input  logic [1:0] mode,
    input  logic       inv,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic       p,
    output logic       q,
    output logic       r
);
    always_comb begin
        p = a;
        q = a ^ b;
        r = c;
        case (mode)
            2'b00: begin
                q = a ^ b;
                r = c;
            end
            2'b01: begin
                q = b;
                r = c ^ (a & b);
            end
            2'b10: begin
                q = (a & c) | (~a & b);
                r = (a & b) | (~a & c);
            end
            default: begin
                // Inverse Peres recovers the original B as a^q before the Toffoli term
                q = a ^ b;
                r = inv ? (c ^ (a & (a ^ b))) : (c ^ (a & b));
            end
        endcase
    end
endmodule

module rev_gate_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic          clk,
    input logic          rst,
    rev_gate_pipe_if.slave bus
);
    logic             v1_q, v1_d;
    logic [1:0]       mode1_q, mode1_d;
    logic             inv1_q, inv1_d;
    logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d, c1_q, c1_d;

    logic             v2_q, v2_d;
    logic [1:0]       mode2_q, mode2_d;
    logic [WIDTH-1:0] p2_q, p2_d, q2_q, q2_d, r2_q, r2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             adv2;
    logic             in_rdy;
    logic             inv_in;
    logic [WIDTH-1:0] res_p, res_q, res_r;

`ifdef REV_GATE_INVERSE_EN
    assign inv_in = bus.in_inv;
`else
    assign inv_in = 1'b0;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        rev_gate_lane u_lane (
            .mode (mode1_q),
            .inv  (inv1_q),
            .a    (a1_q[i]),
            .b    (b1_q[i]),
            .c    (c1_q[i]),
            .p    (res_p[i]),
            .q    (res_q[i]),
            .r    (res_r[i])
        );
    end

    // S2 frees up when empty or draining; S1 can then refill in the same cycle
    assign adv2   = !v2_q || bus.out_ready;
    assign in_rdy = !v1_q || adv2;

    always_comb begin
        v1_d    = v1_q;
        mode1_d = mode1_q;
        inv1_d  = inv1_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        c1_d    = c1_q;
        v2_d    = v2_q;
        mode2_d = mode2_q;
        p2_d    = p2_q;
        q2_d    = q2_q;
        r2_d    = r2_q;
        cnt_d   = cnt_q;

        if (in_rdy) begin
            v1_d = bus.in_valid;
            if (bus.in_valid) begin
                mode1_d = bus.in_mode;
                inv1_d  = inv_in;
                a1_d    = bus.in_a;
                b1_d    = bus.in_b;
                c1_d    = bus.in_c;
            end
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                mode2_d = mode1_q;
                p2_d    = res_p;
                q2_d    = res_q;
                r2_d    = res_r;
            end
        end

        if (v2_q && bus.out_ready) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            mode1_q <= '0;
            inv1_q  <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            c1_q    <= '0;
            v2_q    <= 1'b0;
            mode2_q <= '0;
            p2_q    <= '0;
            q2_q    <= '0;
            r2_q    <= '0;
            cnt_q   <= '0;
        end else begin
            v1_q    <= v1_d;
            mode1_q <= mode1_d;
            inv1_q  <= inv1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            c1_q    <= c1_d;
            v2_q    <= v2_d;
            mode2_q <= mode2_d;
            p2_q    <= p2_d;
            q2_q    <= q2_d;
            r2_q    <= r2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = v2_q;
    assign bus.out_mode  = mode2_q;
    assign bus.out_p     = p2_q;
    assign bus.out_q     = q2_q;
    assign bus.out_r     = r2_q;
    assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_rev_gate_pipe.sv
// Scoreboard bench for rev_gate_pipe: directed gate vectors, backpressure, counter wrap, mid-stream reset, random traffic.
module tb_rev_gate_pipe;
    localparam int W  = 32;
    localparam int CW = 4;

    typedef struct packed {
        logic [1:0]   mode;
        logic [W-1:0] p;
        logic [W-1:0] q;
        logic [W-1:0] r;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_at_edge = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) rst_at_edge <= rst;

    rev_gate_pipe_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    rev_gate_pipe #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t cur_exp;
    int   mcnt = 0;
    int   stall = 0;
    bit   held_v = 0;
    exp_t held;

    function automatic void check(input bit ok, input string nm, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endfunction

    function automatic exp_t mk(input logic [1:0] m, input logic [W-1:0] p, q, r);
        exp_t e;
        e.mode = m; e.p = p; e.q = q; e.r = r;
        return e;
    endfunction

    // Reference: gates described as controlled operations on whole words
    function automatic exp_t model(input logic [1:0] m, input bit inv, input logic [W-1:0] a, b, c);
        exp_t e;
        logic [W-1:0] b0;
        e.mode = m;
        e.p = a;
        e.q = b;
        e.r = c;
        case (m)
            2'd0: e.q = a ^ b;
            2'd1: e.r = c ^ (a & b);
            2'd2: for (int i = 0; i < W; i++) begin
                      if (a[i]) begin e.q[i] = c[i]; e.r[i] = b[i]; end
                  end
            default: begin
                if (!inv) begin
                    e.r = c ^ (a & b);  // Toffoli, then CNOT a->b
                    e.q = a ^ b;
                end else begin
                    b0  = a ^ b;        // undo CNOT, then Toffoli
                    e.q = b0;
                    e.r = c ^ (a & b0);
                end
            end
        endcase
        return e;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        bit   ofire;
        if (rst) begin
            sbq.delete();
            mcnt   = 0;
            held_v = 0;
            stall  = 0;
        end
        if (rst_at_edge) begin
            check(bus.out_valid == 1'b0, "rst_out_valid", bus.out_valid, 0);
            check(bus.op_count == '0, "rst_op_count", bus.op_count, 0);
            check({bus.out_p, bus.out_q, bus.out_r, bus.out_mode} == '0, "rst_out_data", bus.out_p, 0);
            check(bus.in_ready == 1'b1, "rst_in_ready", bus.in_ready, 1);
        end
        if (!rst) begin
            act = mk(bus.out_mode, bus.out_p, bus.out_q, bus.out_r);
            check(bus.op_count == CW'(mcnt), "op_count", bus.op_count, CW'(mcnt));
            if (held_v) begin
                check(bus.out_valid == 1'b1, "hold_valid", bus.out_valid, 1);
                check(act == held, "hold_data", act.r, held.r);
            end
            ofire = bus.out_valid && bus.out_ready;
            if (ofire) begin
                if (sbq.size() == 0) begin
                    check(0, "unexpected_out", act.r, 0);
                end else begin
                    e = sbq.pop_front();
                    check(act.mode == e.mode, "out_mode", act.mode, e.mode);
                    check(act.p == e.p, "out_p", act.p, e.p);
                    check(act.q == e.q, "out_q", act.q, e.q);
                    check(act.r == e.r, "out_r", act.r, e.r);
                end
                mcnt++;
            end
            held_v = bus.out_valid && !bus.out_ready;
            held   = act;
            if (bus.in_valid && bus.in_ready) sbq.push_back(cur_exp);
            if (sbq.size() > 0 && !ofire) stall++;
            else stall = 0;
            if (stall > 100) begin
                check(0, "out_timeout", sbq.size(), 0);
                sbq.delete();
                stall = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] m, input bit inv,
                         input logic [W-1:0] a, b, c, input exp_t e);
        bus.in_valid = v;
        bus.in_mode  = m;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = c;
`ifdef REV_GATE_INVERSE_EN
        bus.in_inv   = inv;
`endif
        cur_exp      = e;
    endtask

    task automatic send(input logic [1:0] m, input bit inv, input logic [W-1:0] a, b, c, input exp_t e);
        bit acc = 0;
        drive(1'b1, m, inv, a, b, c, e);
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
        end
        if (!acc) check(0, "send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        bus.out_ready = 1'b1;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sbq.size() == 0 && !bus.out_valid) break;
        end
        if (k == 100) check(0, "drain_timeout", sbq.size(), 0);
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        logic [1:0] m;
        bit inv;
        logic [W-1:0] a, b, c;

        bus.out_ready = 1'b1;
        drive(1'b0, 2'd0, 1'b0, '0, '0, '0, mk(2'd0, '0, '0, '0));
        step();
        do_reset();

        // Fixed vectors with hand-computed results
        send(2'd1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000));
        @(negedge clk);
        check(bus.out_valid == 1'b0, "latency_c1", bus.out_valid, 0);
        @(negedge clk);
        check(bus.out_valid == 1'b1, "latency_c2", bus.out_valid, 1);
        step();
        drain();
        send(2'd0, 0, 32'hAAAAAAAA, 32'h55555555, 32'h0, mk(2'd0, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h00000000));
        send(2'd2, 0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00FF00FF, mk(2'd2, 32'h0F0F0F0F, 32'hF0FFF0FF, 32'h00F000F0));
        send(2'd3, 0, 32'h12345678, 32'h87654321, 32'hABCDEF01, mk(2'd3, 32'h12345678, 32'h95511559, 32'hA9E9AD21));
`ifdef REV_GATE_INVERSE_EN
        send(2'd3, 1, 32'h12345678, 32'h95511559, 32'hA9E9AD21, mk(2'd3, 32'h12345678, 32'h87654321, 32'hABCDEF01));
`endif
        drain();

        // Stalled output with continuous input: only two items fit
        bus.out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            a = $urandom; b = $urandom; c = $urandom;
            m = 2'(i);
            drive(1'b1, m, 1'b0, a, b, c, model(m, 1'b0, a, b, c));
            @(negedge clk);
            if (bus.in_ready) acc++;
            step();
        end
        check(acc == 2, "bp_accepted", acc, 2);
        check(bus.in_ready == 1'b0, "bp_in_ready", bus.in_ready, 0);
        bus.in_valid = 1'b0;
        drain();

        // Counter wrap: 16 transfers on a 4-bit counter
        do_reset();
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom; c = $urandom;
            m = 2'($urandom_range(0, 3));
            send(m, 1'b0, a, b, c, model(m, 1'b0, a, b, c));
        end
        drain();
        check(bus.op_count == '0, "wrap16", bus.op_count, 0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            a = $urandom; b = $urandom; c = $urandom;
            m = 2'($urandom_range(0, 3));
            inv = 1'b0;
`ifdef REV_GATE_INVERSE_EN
            inv = 1'($urandom_range(0, 1));
`endif
            drive(1'($urandom_range(0, 1)), m, inv, a, b, c, model(m, inv, a, b, c));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.in_valid = 1'b0;
        drain();

        // Reset with data in flight: nothing stale may come out afterwards
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = $urandom; b = $urandom; c = $urandom;
            send(2'd3, 1'b0, a, b, c, model(2'd3, 1'b0, a, b, c));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (5) step();
        a = $urandom; b = $urandom; c = $urandom;
        send(2'd1, 1'b0, a, b, c, model(2'd1, 1'b0, a, b, c));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rev_gate_pipe.md
REV_GATE_PIPE -- requirements
Module: rev_gate_pipe

Interface
REQ-001 SHALL provide parameter WIDTH, 32, lane count (bitwise gate instances).
REQ-002 SHALL provide parameter CNT_W, 16, width of completed-operation counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid input 1 and in_ready output 1, the upstream handshake.
REQ-006 SHALL have port in_mode  input  2  gate select: 00 Feynman, 01 Toffoli, 10 Fredkin, 11 Peres.
REQ-007 SHALL have ports in_a, in_b, in_c  input  WIDTH  gate operands.
REQ-008 SHALL have ports out_valid output 1 and out_ready input 1, the downstream handshake.
REQ-009 SHALL have ports out_p, out_q, out_r  output  WIDTH  gate results.
REQ-010 SHALL have port out_mode  output  2  mode carried with the result.
REQ-011 SHALL have port op_count  output  CNT_W  count of completed output transfers.

Function
REQ-012 SHALL transfer input when in_valid&&in_ready and output when out_valid&&out_ready.
REQ-013 SHALL implement two register stages: S1 captures operands/mode; S2 holds the computed result.
REQ-014 SHALL have latency 2 cycles from input transfer to out_valid with no backpressure.
REQ-015 SHALL sustain one transfer per cycle; in_ready = !v1 || (!v2 || out_ready), with v1/v2 the stage valids.
REQ-016 SHALL accept a new input in the same cycle both stages are full if out_ready=1.
REQ-017 SHALL hold out_p/q/r/mode stable while out_valid&&!out_ready.
REQ-018 SHALL preserve transfer order; no drop, no duplication.
REQ-019 SHALL compute bitwise per lane, forward: Feynman P=A,Q=A^B,R=C; Toffoli P=A,Q=B,R=C^(A&B).
REQ-020 SHALL compute Fredkin P=A,Q=(A&C)|(~A&B),R=(A&B)|(~A&C); Peres P=A,Q=A^B,R=C^(A&B).
REQ-021 SHALL increment op_count on each output transfer, wrapping 2^CNT_W-1 to 0.

Reset
REQ-022 SHALL on rst clear v1, v2, out_valid, out_p/q/r, out_mode and op_count to 0.
REQ-023 SHALL drive in_ready=1 during the cycle following reset release.
REQ-024 SHALL discard in-flight data when rst asserts mid-operation; no output results from it.

Configuration
REQ-025 SHALL compile an inverse-mode path only when macro REV_GATE_INVERSE_EN is defined.
REQ-026 With REV_GATE_INVERSE_EN: extra port in_inv input 1, registered with the operands.
REQ-027 With in_inv=1 and Peres: P=A,Q=A^B,R=C^(A&(A^B)); other modes unaffected (self-inverse).
REQ-028 Without REV_GATE_INVERSE_EN: no in_inv port; forward functions only.

Verification
REQ-029 Toffoli A=B=C=FFFFFFFF, out_ready=1 -> out_valid 2 cycles later, P=Q=FFFFFFFF, R=00000000.
REQ-030 Feynman A=AAAAAAAA,B=55555555,C=0 -> P=AAAAAAAA, Q=FFFFFFFF, R=00000000.
REQ-031 Fredkin A=0F0F0F0F,B=F0F0F0F0,C=00FF00FF -> Q=F0FFF0FF, R=00F000F0.
REQ-032 Peres A=12345678,B=87654321,C=ABCDEF01 -> Q=95511559, R=A9E9AD21; with macro, inv=1 on those outputs -> 12345678,87654321,ABCDEF01.
REQ-033 out_ready=0 for 4 cycles, in_valid=1 continuous -> exactly 2 accepted, in_ready=0, outputs held; release -> in order, op_count +1 per transfer.
REQ-034 CNT_W=4, 16 transfers -> op_count=0; rst mid-stream -> out_valid=0 next cycle, no stale output.
